// File: rtl/ma_dispatch.sv
// ma_dispatch: memory-access command dispatcher.
// Queues load/store commands, reads the base register from the ARF, adds the
// command offset, and launches either NUM_MRF_CH matrix datamover channels or
// one vector (load or store) datamover, then waits for all selected dones.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   ma_ddr4_calib_complete_i    per-DDR4 calibration done; ma_ddr4_linkup_o = registered AND
//   cmd_*                       command valid/ready handshake and payload
//   ma_done_o/ma_err_o/ma_busy_o completion pulse, error qualifier, busy
//   arf_*                       ARF read port (one-cycle read latency)
//   m_dm_mrf_*                  per-channel matrix datamover start/addr/bytes/done
//   m_dm_vrf_ldr_*/m_dm_vrf_str_* vector load / store datamover
//
// Build option: define MA_ALIGN_CHECK_EN to reject misaligned bases
// (ma_done_o with ma_err_o, no datamover start). Undefined: ma_err_o is 0.

module ma_dispatch #(
    parameter int unsigned NUM_OF_DDR4    = 4,
    parameter int unsigned DDR4_ADDRWIDTH = 36,
    parameter int unsigned ARF_ADDRWIDTH  = 5,
    parameter int unsigned VRF_ADDRWIDTH  = 10,
    parameter int unsigned MRF_ADDRWIDTH  = 6,
    parameter int unsigned NUM_MRF_CH     = 4,
    parameter int unsigned MRF_CH_STRIDE  = 128,
    parameter int unsigned MRF_BYTES      = 128,
    parameter int unsigned VRF_BYTES      = 128,
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned ALIGN_LOG2     = 6
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [NUM_OF_DDR4-1:0]                         ma_ddr4_calib_complete_i,
    output logic                                           ma_ddr4_linkup_o,
    input  logic                                           cmd_valid_i,
    output logic                                           cmd_ready_o,
    input  logic                                           cmd_select_v_m_i,
    input  logic                                           cmd_v_load_or_store_i,
    input  logic [VRF_ADDRWIDTH-1:0]                       cmd_v_m_reg_i,
    input  logic [ARF_ADDRWIDTH-1:0]                       cmd_a_reg_i,
    input  logic [DDR4_ADDRWIDTH-1:0]                      cmd_a_offset_i,
    output logic                                           ma_done_o,
    output logic                                           ma_err_o,
    output logic                                           ma_busy_o,
    output logic                                           arf_en_o,
    output logic                                           arf_we_o,
    output logic [ARF_ADDRWIDTH-1:0]                       arf_addr_o,
    input  logic [DDR4_ADDRWIDTH-1:0]                      arf_dout_i,
    output logic [NUM_MRF_CH-1:0]                          m_dm_mrf_start,
    output logic [NUM_MRF_CH-1:0][DDR4_ADDRWIDTH-1:0]      m_dm_mrf_src_axi_addr,
    output logic [NUM_MRF_CH-1:0][MRF_ADDRWIDTH-1:0]       m_dm_mrf_dst_bram_addr,
    output logic [NUM_MRF_CH-1:0][14:0]                    m_dm_mrf_byte_to_trans,
    input  logic [NUM_MRF_CH-1:0]                          m_dm_mrf_done,
    output logic                                           m_dm_vrf_ldr_start,
    output logic [DDR4_ADDRWIDTH-1:0]                      m_dm_vrf_ldr_src_axi_addr,
    output logic [VRF_ADDRWIDTH-1:0]                       m_dm_vrf_ldr_dst_bram_addr,
    output logic [14:0]                                    m_dm_vrf_ldr_byte_to_trans,
    input  logic                                           m_dm_vrf_ldr_done,
    output logic                                           m_dm_vrf_str_start,
    output logic [DDR4_ADDRWIDTH-1:0]                      m_dm_vrf_str_dst_axi_addr,
    output logic [VRF_ADDRWIDTH-1:0]                       m_dm_vrf_str_src_bram_addr,
    output logic [14:0]                                    m_dm_vrf_str_byte_to_trans,
    input  logic                                           m_dm_vrf_str_done
);

    localparam int unsigned AW    = DDR4_ADDRWIDTH;
    localparam int unsigned PTR_W = $clog2(CMD_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned DV_W  = NUM_MRF_CH + 2;   // {str, ldr, mrf[NUM_MRF_CH-1:0]}
    localparam int unsigned BC_W  = 15;

`ifdef MA_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    typedef struct packed {
        logic                     sel_v;
        logic                     load;
        logic [VRF_ADDRWIDTH-1:0] v_m_reg;
        logic [ARF_ADDRWIDTH-1:0] a_reg;
        logic [AW-1:0]            a_offset;
    } cmd_t;

    typedef enum logic [2:0] {IDLE, ARF_RD, CALC, ISSUE, WAIT, DONE} state_t;

    state_t                  state_q, state_d;
    cmd_t                    q_mem [CMD_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        count_q;
    logic                    linkup_q;
    logic                    cur_sel_v_q, cur_load_q;
    logic [VRF_ADDRWIDTH-1:0] cur_vreg_q;
    logic [AW-1:0]           cur_off_q;
    logic [AW-1:0]           base_q;
    logic [DV_W-1:0]         sel_mask_q, sticky_q, done_vec, done_seen;
    logic                    err_q;
    logic                    push, pop, empty, full, align_bad;
    cmd_t                    cmd_in;

    logic [NUM_MRF_CH-1:0][AW-1:0]            mrf_src_q;
    logic [NUM_MRF_CH-1:0][MRF_ADDRWIDTH-1:0] mrf_dst_q;
    logic [NUM_MRF_CH-1:0][BC_W-1:0]          mrf_bytes_q;
    logic [AW-1:0]            ldr_src_q, str_dst_q;
    logic [VRF_ADDRWIDTH-1:0] ldr_dst_q, str_src_q;
    logic [BC_W-1:0]          ldr_bytes_q, str_bytes_q;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(CMD_DEPTH));
    assign push     = cmd_valid_i & cmd_ready_o;
    assign done_vec = {m_dm_vrf_str_done, m_dm_vrf_ldr_done, m_dm_mrf_done};
    assign cmd_in   = '{sel_v: cmd_select_v_m_i, load: cmd_v_load_or_store_i,
                        v_m_reg: cmd_v_m_reg_i, a_reg: cmd_a_reg_i, a_offset: cmd_a_offset_i};

    // Next-state and pop decision
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        align_bad = ALIGN_CHK && (base_q[ALIGN_LOG2-1:0] != '0);
        done_seen = sticky_q | (done_vec & sel_mask_q);
        unique case (state_q)
            IDLE:   if (!empty) begin
                        pop     = 1'b1;
                        state_d = ARF_RD;
                    end
            ARF_RD: state_d = CALC;
            CALC:   state_d = align_bad ? DONE : ISSUE;
            ISSUE:  state_d = WAIT;
            WAIT:   if ((done_seen & sel_mask_q) == sel_mask_q) state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command queue storage (pointers and count carry the reset)
    always_ff @(posedge clk) begin
        if (push) q_mem[wr_ptr_q] <= cmd_in;
    end

    // State, queue control, address calculation and sticky done capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            linkup_q    <= 1'b0;
            cur_sel_v_q <= 1'b0;
            cur_load_q  <= 1'b0;
            cur_vreg_q  <= '0;
            cur_off_q   <= '0;
            base_q      <= '0;
            sel_mask_q  <= '0;
            sticky_q    <= '0;
            err_q       <= 1'b0;
            mrf_src_q   <= '0;
            mrf_dst_q   <= '0;
            mrf_bytes_q <= '0;
            ldr_src_q   <= '0;
            ldr_dst_q   <= '0;
            ldr_bytes_q <= '0;
            str_dst_q   <= '0;
            str_src_q   <= '0;
            str_bytes_q <= '0;
        end else begin
            state_q  <= state_d;
            linkup_q <= &ma_ddr4_calib_complete_i;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            if (pop) begin
                cur_sel_v_q <= q_mem[rd_ptr_q].sel_v;
                cur_load_q  <= q_mem[rd_ptr_q].load;
                cur_vreg_q  <= q_mem[rd_ptr_q].v_m_reg;
                cur_off_q   <= q_mem[rd_ptr_q].a_offset;
            end
            if (state_q == ARF_RD) base_q <= arf_dout_i + cur_off_q;
            if (state_q == CALC) begin
                err_q <= align_bad;
                if (!cur_sel_v_q) begin
                    sel_mask_q <= {2'b00, {NUM_MRF_CH{1'b1}}};
                    for (int unsigned k = 0; k < NUM_MRF_CH; k++) begin
                        mrf_src_q[k]   <= base_q + AW'(k * MRF_CH_STRIDE);
                        mrf_dst_q[k]   <= cur_vreg_q[MRF_ADDRWIDTH-1:0];
                        mrf_bytes_q[k] <= BC_W'(MRF_BYTES);
                    end
                end else if (cur_load_q) begin
                    sel_mask_q  <= {2'b01, NUM_MRF_CH'(0)};
                    ldr_src_q   <= base_q;
                    ldr_dst_q   <= cur_vreg_q;
                    ldr_bytes_q <= BC_W'(VRF_BYTES);
                end else begin
                    sel_mask_q  <= {2'b10, NUM_MRF_CH'(0)};
                    str_dst_q   <= base_q;
                    str_src_q   <= cur_vreg_q;
                    str_bytes_q <= BC_W'(VRF_BYTES);
                end
            end
            // Dones count only once the starts have gone out
            if (state_q == ISSUE || state_q == WAIT) sticky_q <= done_seen;
            else if (state_q == DONE)                sticky_q <= '0;
        end
    end

    // Moore outputs decoded from registered state
    assign ma_ddr4_linkup_o = linkup_q;
    assign cmd_ready_o      = linkup_q & ~full;
    assign ma_busy_o        = (state_q != IDLE) | ~empty;
    assign ma_done_o        = (state_q == DONE);
    assign ma_err_o         = (state_q == DONE) & err_q;
    assign arf_en_o         = pop;
    assign arf_we_o         = 1'b0;
    assign arf_addr_o       = pop ? q_mem[rd_ptr_q].a_reg : '0;

    assign m_dm_mrf_start         = (state_q == ISSUE) ? sel_mask_q[NUM_MRF_CH-1:0] : '0;
    assign m_dm_mrf_src_axi_addr  = mrf_src_q;
    assign m_dm_mrf_dst_bram_addr = mrf_dst_q;
    assign m_dm_mrf_byte_to_trans = mrf_bytes_q;

    assign m_dm_vrf_ldr_start         = (state_q == ISSUE) & sel_mask_q[NUM_MRF_CH];
    assign m_dm_vrf_ldr_src_axi_addr  = ldr_src_q;
    assign m_dm_vrf_ldr_dst_bram_addr = ldr_dst_q;
    assign m_dm_vrf_ldr_byte_to_trans = ldr_bytes_q;

    assign m_dm_vrf_str_start         = (state_q == ISSUE) & sel_mask_q[NUM_MRF_CH+1];
    assign m_dm_vrf_str_dst_axi_addr  = str_dst_q;
    assign m_dm_vrf_str_src_bram_addr = str_src_q;
    assign m_dm_vrf_str_byte_to_trans = str_bytes_q;

endmodule
